// File: rtl/param_shift_pkg.sv
// param_shift_pkg: mode and FSM state encodings shared by the shift unit
package param_shift_pkg;
  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/param_shift_unit_step.sv
// shift_step: combinational one-position shift in the selected mode and direction
module shift_step
  import param_shift_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             bit_out
);
  logic fill_l, fill_r;
  always_comb begin
    fill_l  = mode == MODE_ROT ? q[WIDTH-1] : mode == MODE_SER ? sin : 1'b0;
    fill_r  = mode == MODE_ARI ? q[WIDTH-1] : mode == MODE_ROT ? q[0] : mode == MODE_SER ? sin : 1'b0;
    q_next  = dir ? {q[WIDTH-2:0], fill_l} : {fill_r, q[WIDTH-1:1]};
    bit_out = dir ? q[WIDTH-1] : q[0];
  end
endmodule

// File: rtl/param_shift_unit.sv
// param_shift_unit: load/start/busy/done shift register, one step per clock
module param_shift_unit
  import param_shift_pkg::*;
#(
  parameter int WIDTH = 12,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic             E,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, amt_c;
  logic dir_r, bit_out, go;
  logic [1:0] mode_r;
  logic [WIDTH-1:0] q_next;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q(Q), .dir(dir_r), .mode(mode_r), .sin(sin), .q_next(q_next), .bit_out(bit_out)
  );
  assign busy = state == S_SHIFT;
  assign done = state == S_DONE;
  always_comb begin
    amt_c   = amt > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : amt;
    go      = state == S_IDLE && !L && start;
    state_n = go ? (amt_c == '0 ? S_DONE : S_SHIFT)
            : state == S_SHIFT ? (cnt == CNT_W'(1) ? S_DONE : S_SHIFT)
            : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      Q      <= '0;
      sout   <= 1'b0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      mode_r <= MODE_LOG;
    end else begin
      state <= state_n;
      if (state == S_IDLE && L) Q <= D;
      if (go) begin
        cnt    <= amt_c;
        dir_r  <= E;
        mode_r <= mode;
      end
      if (state == S_SHIFT) begin
        Q    <= q_next;
        sout <= bit_out;
        cnt  <= cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_param_shift_unit.sv
// tb_param_shift_unit: directed and random checks against a closed-form shift model
module tb_param_shift_unit;
  localparam int W = 12;
  localparam int CW = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;
  logic clk = 0, rst = 1, L = 0, start = 0, E = 0, sin = 0;
  logic [W-1:0] D = '0;
  logic [1:0] mode = '0;
  logic [CW-1:0] amt = '0;
  logic [W-1:0] Q;
  logic sout, busy, done;
  int vectors = 0, errors = 0;
  int m_q = 0, m_sout = 0, m_q0 = 0, m_k = 0, m_n = 0, m_phase = 0, m_dir = 0, m_mode = 0;
  int nbusy = 0, ndone = 0;
  int sins[$];
  param_shift_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .L(L), .D(D), .start(start), .E(E), .mode(mode),
    .amt(amt), .sin(sin), .Q(Q), .sout(sout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic int after(int k);
    int r, sx;
    r = 0;
    if (m_dir != 0) begin
      r = m_q0 << k;
      if (m_mode == 2) r = r | (m_q0 >> (W - k));
      if (m_mode == 3) for (int i = 0; i < k; i++) if (sins[i] != 0) r = r | (1 << (k - 1 - i));
    end else begin
      r = m_q0 >> k;
      if (m_mode == 1) begin
        sx = ((m_q0 >> (W - 1)) & 1) != 0 ? (m_q0 | ~MASK) : m_q0;
        r = sx >>> k;
      end
      if (m_mode == 2) r = r | (m_q0 << (W - k));
      if (m_mode == 3) for (int i = 0; i < k; i++) if (sins[i] != 0) r = r | (1 << (W - k + i));
    end
    return r & MASK;
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_q = 0;
      m_sout = 0;
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (L) m_q = int'(D);
      else if (start) begin
        m_n = int'(amt) > W ? W : int'(amt);
        m_q0 = m_q;
        m_k = 0;
        m_dir = int'(E);
        m_mode = int'(mode);
        sins.delete();
        m_phase = m_n == 0 ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      sins.push_back(int'(sin));
      m_k++;
      m_q = after(m_k);
      m_sout = m_dir != 0 ? (m_q0 >> (W - m_k)) & 1 : (m_q0 >> (m_k - 1)) & 1;
      if (m_k == m_n) m_phase = 2;
    end else m_phase = 0;
    #1;
    check("q", int'(Q), m_q);
    check("sout", int'(sout), m_sout);
    check("busy", int'(busy), int'(m_phase == 1));
    check("done", int'(done), int'(m_phase == 2));
    if (busy) nbusy++;
    if (done) ndone++;
    @(negedge clk);
  endtask
  task automatic load(input int d);
    L = 1;
    D = W'(d);
    tick();
    L = 0;
  endtask
  task automatic run_op(input int e, input int md, input int am);
    start = 1;
    E = e[0];
    mode = md[1:0];
    amt = CW'(am);
    nbusy = 0;
    ndone = 0;
    tick();
    start = 0;
    repeat (W + 3) tick();
  endtask
  initial begin
    tick();
    tick();
    check("rst_q", int'(Q), 0);
    check("rst_busy", int'(busy), 0);
    rst = 0;
    load(55);
    check("t1_q", int'(Q), 'h037);
    check("t1_done", int'(done), 0);
    run_op(1, 0, 3);
    check("t2_q", int'(Q), 'h1B8);
    check("t2_sout", int'(sout), 0);
    check("t2_nbusy", nbusy, 3);
    check("t2_ndone", ndone, 1);
    load('h800);
    run_op(0, 1, 2);
    check("t3_ari", int'(Q), 'hE00);
    load('h800);
    run_op(0, 0, 2);
    check("t3_log", int'(Q), 'h200);
    load('h037);
    run_op(0, 2, 4);
    check("t4_rot", int'(Q), 'h703);
    run_op(0, 2, 15);
    check("t4_clamp_q", int'(Q), 'h703);
    check("t4_nbusy", nbusy, 12);
    load('h037);
    sin = 1;
    run_op(1, 3, 2);
    sin = 0;
    check("t5_ser", int'(Q), 'h0DF);
    run_op(1, 0, 0);
    check("t5_zero_nbusy", nbusy, 0);
    check("t5_zero_ndone", ndone, 1);
    check("t5_zero_q", int'(Q), 'h0DF);
    start = 1; E = 1; mode = 0; amt = CW'(10); ndone = 0;
    tick();
    start = 0;
    tick();
    L = 1; D = '1;
    tick();
    L = 0;
    repeat (12) tick();
    check("t6_noload", int'(Q), ('h0DF << 10) & MASK);
    check("t6_ndone", ndone, 1);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_q", int'(Q), 0);
    check("t6_rst_busy", int'(busy), 0);
    ndone = 0;
    repeat (5) tick();
    check("t6_nodone", ndone, 0);
    repeat (800) begin
      rst = $urandom_range(0, 59) == 0;
      L = $urandom_range(0, 3) == 0;
      D = W'($urandom);
      start = $urandom_range(0, 2) == 0;
      E = 1'($urandom);
      mode = 2'($urandom);
      amt = CW'($urandom);
      sin = 1'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
